dcache_ctrl: RTL
================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage of the pipelined MIPS core. It serves MemRead/MemWrite from the EX/MEM register. It produces `readData` and `hit` for the MEM/WB register and drives `stall` to freeze the pipeline on misses and writes. Misses and writes go to main memory over a req/ack word interface.

## Interface
- `INDEX_BITS`, 4: line index width; the cache has 2^INDEX_BITS lines.
- `WORDS_PER_LINE`, 4: 32-bit words per line; must be a power of 2 and ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `MemRead` in 1: load request, held while `stall`=1.
- `MemWrite` in 1: store request, held while `stall`=1.
- `address` in 32: byte address, word-aligned; bits [1:0] are ignored.
- `writeData` in 32: store data.
- `readData` out 32: load data to MEM/WB.
- `hit` out 1: access hit indication to MEM/WB.
- `stall` out 1: freezes PC, IF/ID, ID/EX and EX/MEM; MEM/WB captures a bubble.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 32: word-aligned memory address.
- `mem_wdata` out 32: memory write data.
- `mem_ack` in 1: one-cycle completion pulse for the current word.
- `mem_rdata` in 32: read data, valid when `mem_ack`=1.

## Operation
- Address split, with W = log2(WORDS_PER_LINE):
  - word select = [W+1:2]
  - index = [W+1+INDEX_BITS:W+2]
  - tag = remaining upper bits
- Storage per line: valid bit, tag, and WORDS_PER_LINE data words.
- States: IDLE, REFILL, WRITE, DONE.
- **IDLE, MemWrite=1:** `stall`=1, latch address/data and whether the write hits; go to WRITE. MemWrite has priority if both requests are set, which is illegal but must be defined.
- **IDLE, MemRead=1, valid and tag match:** `hit`=1, `readData`=word, `stall`=0, combinational in the same cycle. No state change.
- **IDLE, MemRead=1, miss:** `stall`=1, `hit`=0, clear word counter, go to REFILL.
- **IDLE, no request:** `hit`=0, `stall`=0, `readData`=0.
- **REFILL:**
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`={tag,index,cnt,2'b00}.
  - On each `mem_ack`, write `mem_rdata` into the line word `cnt` and increment `cnt`.
  - On the ack for the last word, write tag, set valid, and go to IDLE. The held MemRead then hits.
  - Valid stays 0 for the whole refill; the valid bit is cleared at refill entry.
- **WRITE:**
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr`=latched address, `mem_wdata`=latched data.
  - On `mem_ack`: if the latched write-hit flag is set, update the cached word. Go to DONE.
- **DONE:** one cycle with `stall`=0 and `hit`=latched write-hit flag, so the pipeline advances past the store. Inputs are ignored. Next state is IDLE.
- The memory interface has no other transactions; `mem_req`=0 in IDLE and DONE.

## Timing
- Reset (async) values:
  - state IDLE, all valid bits 0, `cnt`=0
  - `mem_req`/`mem_we`=0, `mem_addr`/`mem_wdata`=0
  - `stall`=0, `hit`=0, `readData`=0
- Reset mid-refill or mid-write aborts immediately: `mem_req` drops in the reset cycle and the partial line stays invalid.
- The data arrays need no reset.
- Handshake rules:
  - `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are stable from assertion until the edge at which `mem_ack`=1.
  - The address advances in the cycle after each ack.
  - `mem_req` may stay high between refill words.
  - `mem_ack` is legal in the first `mem_req` cycle (zero-wait memory).
- Latency, zero-wait memory:
  - read hit: 0 stall cycles
  - read miss: 1 + WORDS_PER_LINE stall cycles (5 at default); the data returns in the following IDLE cycle
  - store: 2 stall cycles (IDLE detect, WRITE), then DONE
- Each additional memory wait cycle adds one stall cycle per word.
- `cnt` is WORDS_PER_LINE-wide modulo and wraps to 0 after the last word.
- No tag-compare ambiguity: invalid lines never hit, even when tag bits match the reset contents.

## Test plan
1. Reset, preload memory with word at 0x40 = 0x11111111 (and 0x44/0x48/0x4C), MemRead 0x40 → `stall`=1 for 5 cycles; `mem_addr` = 0x40, 0x44, 0x48, 0x4C with `mem_we`=0; then `hit`=1, `readData`=0x11111111, `stall`=0.
2. MemRead 0x4C right after → `hit`=1 in the same cycle, `readData` = memory word 0x4C, `mem_req` stays 0.
3. MemWrite 0x48 data 0xDEADBEEF (line resident) → `mem_req`=1, `mem_we`=1, `mem_wdata`=0xDEADBEEF; DONE shows `hit`=1 and `stall`=0. A following MemRead 0x48 returns 0xDEADBEEF with no `mem_req`.
4. MemRead 0x1040 (same index, new tag) → full refill from 0x1040–0x104C. Then MemRead 0x40 misses again and refetches.
5. MemWrite 0x200 data 0x5 (miss) → one memory write, DONE `hit`=0, no line allocated. MemRead 0x200 then misses.
6. Memory with 3-cycle ack delay; assert `rst_n`=0 after the 2nd refill ack → `mem_req`=0 immediately. After release, MemRead of the same address misses and refills all 4 words.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the
// MEM stage. Read misses refill a whole line over the req/ack word interface;
// every store goes to memory and updates the cached copy only on a hit.
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS     = 4,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        hit,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned OffBits = $clog2(WORDS_PER_LINE);
  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned IdxLsb  = OffBits + 2;
  localparam int unsigned TagLsb  = IdxLsb + INDEX_BITS;
  localparam int unsigned TagBits = 32 - TagLsb;
  localparam logic [OffBits-1:0] LastWord = OffBits'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {StIdle, StRefill, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [OffBits-1:0]  cnt_q, cnt_d;
  logic [Lines-1:0]    valid_q;
  logic [TagBits-1:0]  tag_q  [Lines];
  logic [31:0]         data_q [Lines][WORDS_PER_LINE];
  logic [31:2]         wr_addr_q;
  logic [31:0]         wr_data_q;
  logic                wr_hit_q;

  // Address fields of the live request and of the latched store.
  logic [OffBits-1:0]    req_word, wr_word;
  logic [INDEX_BITS-1:0] req_idx, wr_idx;
  logic [TagBits-1:0]    req_tag;
  logic                  lookup_hit;
  logic                  unused_addr;

  assign req_word    = address[IdxLsb-1:2];
  assign req_idx     = address[TagLsb-1:IdxLsb];
  assign req_tag     = address[31:TagLsb];
  assign wr_word     = wr_addr_q[IdxLsb-1:2];
  assign wr_idx      = wr_addr_q[TagLsb-1:IdxLsb];
  assign lookup_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr = ^address[1:0];

  logic latch_wr, clr_valid, fill_en, fill_last, upd_en;

  // Next-state, array-update strobes and all outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_wr  = 1'b0;
    clr_valid = 1'b0;
    fill_en   = 1'b0;
    fill_last = 1'b0;
    upd_en    = 1'b0;
    readData  = '0;
    hit       = 1'b0;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (MemWrite) begin
          // Stores win over loads if both are raised.
          stall    = 1'b1;
          latch_wr = 1'b1;
          state_d  = StWrite;
        end else if (MemRead) begin
          if (lookup_hit) begin
            hit      = 1'b1;
            readData = data_q[req_idx][req_word];
          end else begin
            stall     = 1'b1;
            cnt_d     = '0;
            clr_valid = 1'b1;
            state_d   = StRefill;
          end
        end
      end
      StRefill: begin
        // The load is held during the stall, so the live address names the line.
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {address[31:IdxLsb], cnt_q, 2'b00};
        if (mem_ack) begin
          fill_en = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastWord) begin
            fill_last = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StWrite: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wr_addr_q, 2'b00};
        mem_wdata = wr_data_q;
        if (mem_ack) begin
          upd_en  = wr_hit_q;
          state_d = StDone;
        end
      end
      StDone: begin
        hit     = wr_hit_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, valid bits and the latched store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      valid_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_hit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (clr_valid) valid_q[req_idx] <= 1'b0;
      if (fill_last) valid_q[req_idx] <= 1'b1;
      if (latch_wr) begin
        wr_addr_q <= address[31:2];
        wr_data_q <= writeData;
        wr_hit_q  <= lookup_hit;
      end
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en)   data_q[req_idx][cnt_q]   <= mem_rdata;
    if (fill_last) tag_q[req_idx]           <= req_tag;
    if (upd_en)    data_q[wr_idx][wr_word]  <= wr_data_q;
  end

endmodule
